// File: rtl/dgldpc_conv_pkg.sv
// Shared types for the LLR sign-magnitude / two's-complement converter.
// The stage-1 record carries the per-lane intermediate form between the two pipeline stages.
package dgldpc_conv_pkg;

    localparam int LLR_W      = 6;
    localparam int CONV_LANES = 4;

    typedef enum logic {
        MODE_TC2SM = 1'b0,
        MODE_SM2TC = 1'b1
    } conv_mode_e;

    // oc is sized by LLR_W; lanes narrower than LLR_W use its low W bits
    typedef struct packed {
        logic [LLR_W-1:0] oc;
        logic             c;
        logic             z;
        logic             mn;
        conv_mode_e       mode;
    } conv_s1_t;

endpackage

// File: rtl/llr_conv_lane.sv
// One lane of the converter: purely combinational stage-1 (pre-conversion)
// and stage-2 (finish) functions; the registers between them live in the top.
module llr_conv_lane
    import dgldpc_conv_pkg::*;
#(
    parameter int W = LLR_W
) (
    input  logic [W-1:0] x,
    input  conv_mode_e   mode,
    output conv_s1_t     s1_d,
    input  conv_s1_t     s1_q,
    output logic [W-1:0] y,
    output logic         sat
);

    logic         s;
    logic [W-2:0] m;
    logic [W-2:0] mag;
    logic [W-1:0] oc;

    assign s   = x[W-1];
    assign m   = x[W-2:0];
    // low bits of a two's-complement negation depend only on the low input bits
    assign mag = s ? (~m + (W-1)'(1)) : m;
    assign oc  = s1_q.oc[W-1:0];

    always_comb begin
        s1_d      = '0;
        s1_d.mode = mode;
        if (mode == MODE_SM2TC) begin
            s1_d.oc = LLR_W'({s, m ^ {(W-1){s}}});
            s1_d.c  = s & (|m);
            s1_d.z  = s & ~(|m);
        end else begin
            s1_d.oc = LLR_W'({s, mag});
            s1_d.mn = (x == {1'b1, {(W-1){1'b0}}});
        end
    end

    always_comb begin
        y   = '0;
        sat = 1'b0;
        if (s1_q.mode == MODE_SM2TC) begin
            if (!s1_q.z) begin
                y = oc + {{(W-1){1'b0}}, s1_q.c};
            end
        end else if (s1_q.mn) begin
            y   = '1;
            sat = 1'b1;
        end else begin
            y = oc;
        end
    end

endmodule

// File: rtl/llr_sm_tc_conv_pipe.sv
// Multi-lane two-stage SM<->TC LLR converter with valid/ready on both sides,
// per-lane saturation flags and a saturating count of delivered saturations.
module llr_sm_tc_conv_pipe
    import dgldpc_conv_pkg::*;
#(
    parameter int W     = LLR_W,
    parameter int LANES = CONV_LANES,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_mode,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [LANES*W-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [LANES*W-1:0] o_data,
    output logic [LANES-1:0]   o_sat,
    input  logic               i_clr_cnt,
    output logic [CNT_W-1:0]   o_sat_cnt
);

    logic               s1_valid;
    conv_s1_t           s1_q [LANES];
    conv_s1_t           s1_d [LANES];
    logic [LANES*W-1:0] y_d;
    logic [LANES-1:0]   sat_d;
    logic               s2_load;
    logic               out_fire;
    logic [CNT_W:0]     pop;
    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   cnt_next;

    // stage 2 frees up when empty or draining; stage 1 moves on the same condition
    assign s2_load  = !o_valid || i_ready;
    assign o_ready  = !s1_valid || s2_load;
    assign out_fire = o_valid && i_ready;

    for (genvar gk = 0; gk < LANES; gk++) begin : g_lane
        llr_conv_lane #(.W(W)) u_lane (
            .x    (i_data[gk*W +: W]),
            .mode (conv_mode_e'(i_mode)),
            .s1_d (s1_d[gk]),
            .s1_q (s1_q[gk]),
            .y    (y_d[gk*W +: W]),
            .sat  (sat_d[gk])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                s1_q[k] <= '0;
            end
        end else if (o_ready) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= '0;
        end else if (s2_load) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data <= y_d;
                o_sat  <= sat_d;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < LANES; k++) begin
            pop = pop + (CNT_W+1)'(o_sat[k]);
        end
        sum      = {1'b0, o_sat_cnt} + pop;
        cnt_next = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // clear takes priority over a simultaneous delivery
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sat_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_sat_cnt <= '0;
        end else if (out_fire) begin
            o_sat_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_llr_sm_tc_conv_pipe.sv
// Self-checking bench for llr_sm_tc_conv_pipe: fixed vector table, hand-written
// handshake/counter/reset sequences and a randomized stream against a scoreboard model.
module tb_llr_sm_tc_conv_pipe;

    localparam int W       = 6;
    localparam int LANES   = 4;
    localparam int CNT_W   = 4;
    localparam int DW      = W * LANES;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_mode;
    logic             i_valid;
    logic             o_ready;
    logic [DW-1:0]    i_data;
    logic             o_valid;
    logic             i_ready;
    logic [DW-1:0]    o_data;
    logic [LANES-1:0] o_sat;
    logic             i_clr_cnt;
    logic [CNT_W-1:0] o_sat_cnt;

    llr_sm_tc_conv_pipe #(.W(W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_mode    (i_mode),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_sat     (o_sat),
        .i_clr_cnt (i_clr_cnt),
        .o_sat_cnt (o_sat_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0]    data;
        logic [LANES-1:0] sat;
    } beat_t;

    typedef struct {
        logic             mode;
        logic [DW-1:0]    data;
        logic [DW-1:0]    exp_data;
        logic [LANES-1:0] exp_sat;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    exp_cnt = 0;
    int    delivered = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    vec_t  vecs[6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [DW-1:0] data, input logic valid);
        i_mode  = mode;
        i_data  = data;
        i_valid = valid;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lanes4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                             input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: interpret lane values as integers and convert by arithmetic
    function automatic void model_lane(input logic mode, input int x, output int y, output bit sat);
        int half;
        int full;
        int v;
        half = 1 << (W - 1);
        full = 1 << W;
        sat  = 1'b0;
        if (mode) begin
            v = (x >= half) ? -(x - half) : x;
            y = (v + full) % full;
        end else begin
            v = (x >= half) ? x - full : x;
            if (v == -half) begin
                y   = full - 1;
                sat = 1'b1;
            end else if (v < 0) begin
                y = half + (-v);
            end else begin
                y = v;
            end
        end
    endfunction

    function automatic beat_t model_beat(input logic mode, input logic [DW-1:0] d);
        beat_t b;
        int    x;
        int    y;
        bit    s;
        for (int k = 0; k < LANES; k++) begin
            x = 0;
            x[W-1:0] = d[k*W +: W];
            model_lane(mode, x, y, s);
            b.data[k*W +: W] = y[W-1:0];
            b.sat[k]         = s;
        end
        return b;
    endfunction

    // Scoreboard: expected beats queued on accept, compared on delivery; counter tracked alongside
    always @(negedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            checkOutput("sat_cnt", 64'(o_sat_cnt), 64'(exp_cnt));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(o_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("sb_data", 64'(o_data), 64'(mon_e.data));
                    checkOutput("sb_sat", 64'(o_sat), 64'(mon_e.sat));
                    delivered++;
                    if (!i_clr_cnt) begin
                        exp_cnt = exp_cnt + $countones(mon_e.sat);
                        if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
                    end
                end
            end
            if (i_clr_cnt) exp_cnt = 0;
            if (i_valid && o_ready) exp_q.push_back(model_beat(i_mode, i_data));
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        applyStimulus(v.mode, v.data, 1'b1);
        i_ready = 1'b1;
        @(negedge i_clk);
        checkOutput({tag, "_accept"}, 64'(o_ready), 64'(1));
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
        end while (!o_valid && lat < 8);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(2));
        checkOutput({tag, "_data"}, 64'(o_data), 64'(v.exp_data));
        checkOutput({tag, "_sat"}, 64'(o_sat), 64'(v.exp_sat));
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic          il_mode [3];
        logic [DW-1:0] il_data;
        beat_t         il_exp [3];
        logic [DW-1:0] held;
        logic [DW-1:0] cur;
        int            got;
        int            sent;
        int            stall;
        int            start;
        bit            first_seen;
        bit            saw_block;

        vecs[0] = '{1'b1, lanes4(6'b000101, 6'b100101, 6'b100000, 6'b111111),
                          lanes4(6'b000101, 6'b111011, 6'b000000, 6'b100001), 4'b0000};
        vecs[1] = '{1'b0, lanes4(6'b111011, 6'b100000, 6'b000000, 6'b011111),
                          lanes4(6'b100101, 6'b111111, 6'b000000, 6'b011111), 4'b0010};
        vecs[2] = '{1'b1, lanes4(6'b000000, 6'b011111, 6'b100001, 6'b000001),
                          lanes4(6'b000000, 6'b011111, 6'b111111, 6'b000001), 4'b0000};
        vecs[3] = '{1'b0, lanes4(6'b000001, 6'b111111, 6'b100001, 6'b010000),
                          lanes4(6'b000001, 6'b100001, 6'b111111, 6'b010000), 4'b0000};
        vecs[4] = '{1'b0, lanes4(6'b100000, 6'b100000, 6'b100000, 6'b100000),
                          lanes4(6'b111111, 6'b111111, 6'b111111, 6'b111111), 4'b1111};
        vecs[5] = '{1'b1, lanes4(6'b100000, 6'b100000, 6'b011111, 6'b111110),
                          lanes4(6'b000000, 6'b000000, 6'b011111, 6'b100010), 4'b0000};

        i_rst     = 1'b1;
        i_ready   = 1'b0;
        i_clr_cnt = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("ready_in_reset", 64'(o_ready), 64'(1));
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checkOutput("rst_valid", 64'(o_valid), 64'(0));
        checkOutput("rst_data", 64'(o_data), 64'(0));
        checkOutput("rst_sat", 64'(o_sat), 64'(0));
        checkOutput("rst_cnt", 64'(o_sat_cnt), 64'(0));
        checkOutput("rst_ready", 64'(o_ready), 64'(1));
        tick();

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) checkOutput("cnt_after_tc", 64'(o_sat_cnt), 64'(1));
        end

        $display("[TB] mode interleave");
        il_mode = '{1'b1, 1'b0, 1'b1};
        il_data = lanes4(6'b100001, 6'b000101, 6'b111010, 6'b100000);
        il_exp[0] = '{lanes4(6'b111111, 6'b000101, 6'b100110, 6'b000000), 4'b0000};
        il_exp[1] = '{lanes4(6'b111111, 6'b000101, 6'b100110, 6'b111111), 4'b1000};
        il_exp[2] = il_exp[0];
        i_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 3) applyStimulus(il_mode[c], il_data, 1'b1);
            else       applyStimulus(1'b0, '0, 1'b0);
            @(negedge i_clk);
            if (o_valid) begin
                if (got < 3) begin
                    checkOutput("il_data", 64'(o_data), 64'(il_exp[got].data));
                    checkOutput("il_sat", 64'(o_sat), 64'(il_exp[got].sat));
                end
                got++;
            end
            tick();
        end
        checkOutput("il_count", 64'(got), 64'(3));

        $display("[TB] backpressure");
        sent = 0;
        stall = 0;
        first_seen = 1'b0;
        saw_block = 1'b0;
        held = '0;
        start = delivered;
        cur = DW'($urandom);
        for (int c = 0; c < 60; c++) begin
            if (sent == 6 && delivered - start == 6) break;
            applyStimulus(1'b1, cur, sent < 6);
            i_ready = first_seen && stall >= 3;
            @(negedge i_clk);
            if (!o_ready) saw_block = 1'b1;
            if (o_valid && !i_ready) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    held = o_data;
                end else begin
                    checkOutput("bp_hold", 64'(o_data), 64'(held));
                end
                stall++;
            end
            if (i_valid && o_ready) begin
                sent++;
                cur = DW'($urandom);
            end
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        i_ready = 1'b1;
        checkOutput("bp_delivered", 64'(delivered - start), 64'(6));
        checkOutput("bp_ready_dropped", 64'(saw_block), 64'(1));

        $display("[TB] counter saturation and clear");
        i_clr_cnt = 1'b1;
        tick();
        i_clr_cnt = 1'b0;
        checkOutput("cnt_cleared", 64'(o_sat_cnt), 64'(0));
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, lanes4(6'b100000, 6'b000011, 6'b110000, 6'b011111), 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        repeat (4) tick();
        checkOutput("cnt_saturated", 64'(o_sat_cnt), 64'(CNT_MAX));
        i_ready = 1'b0;
        applyStimulus(1'b0, lanes4(6'b100000, 6'b000001, 6'b000010, 6'b000011), 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        checkOutput("clr_setup_valid", 64'(o_valid), 64'(1));
        i_ready   = 1'b1;
        i_clr_cnt = 1'b1;
        tick();
        i_clr_cnt = 1'b0;
        checkOutput("clr_wins", 64'(o_sat_cnt), 64'(0));

        $display("[TB] random stream");
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < LANES; k++) begin
                cur[k*W +: W] = ($urandom_range(0, 3) == 0) ? 6'b100000 : W'($urandom);
            end
            applyStimulus(1'($urandom), cur, $urandom_range(0, 3) != 0);
            i_ready   = $urandom_range(0, 3) != 0;
            i_clr_cnt = $urandom_range(0, 31) == 0;
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        i_ready   = 1'b1;
        i_clr_cnt = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        checkOutput("rand_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] reset mid-operation");
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, DW'($urandom), 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge i_clk);
        checkOutput("full_valid", 64'(o_valid), 64'(1));
        checkOutput("full_ready", 64'(o_ready), 64'(0));
        tick();
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(o_valid), 64'(0));
        checkOutput("midrst_ready", 64'(o_ready), 64'(1));
        tick();
        tick();
        i_rst   = 1'b0;
        i_ready = 1'b1;
        checkOutput("post_rst_ready", 64'(o_ready), 64'(1));
        checkOutput("post_rst_cnt", 64'(o_sat_cnt), 64'(0));
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            checkOutput("no_stale", 64'(o_valid), 64'(0));
            tick();
        end
        run_vec(vecs[1], "post_rst_vec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
